// File: rtl/imem_loader_pkg.sv
// Shared definitions for the polirv instruction-side loader: FSM state type and data widths.
package polirv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } ld_state_t;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned BYTE_W  = 8;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream load channel into the instruction memory loader.
//   ld_start : pulse, begin a new load
//   ld_valid : ld_byte valid this cycle
//   ld_byte  : program byte, little-endian within each word
//   ld_last  : final byte of the image
//   ld_ready : loader accepts a byte this cycle
interface imem_loader_if;
  import polirv_pkg::*;

  logic              ld_start;
  logic              ld_valid;
  logic [BYTE_W-1:0] ld_byte;
  logic              ld_last;
  logic              ld_ready;

  modport master (output ld_start, ld_valid, ld_byte, ld_last, input ld_ready);
  modport slave  (input ld_start, ld_valid, ld_byte, ld_last, output ld_ready);

endinterface

// File: rtl/imem_bank.sv
// Instruction word array: synchronous byte-lane write, synchronous clear-all, async read.
//   clk, rst : clock, synchronous active-high reset (clears all words)
//   clr      : synchronous clear of all words
//   we/waddr/lane/wbyte : write wbyte into byte lane 'lane' of word 'waddr'
//   raddr/rdata         : asynchronous word read
module imem_bank
  import polirv_pkg::*;
#(
  parameter int unsigned WADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               we,
  input  logic [WADDR_W-1:0] waddr,
  input  logic [1:0]         lane,
  input  logic [BYTE_W-1:0]  wbyte,
  input  logic [WADDR_W-1:0] raddr,
  output logic [INSTR_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << WADDR_W;

  logic [INSTR_W-1:0] mem [DEPTH];

  // Clear has priority over write so a byte coinciding with a restart is dropped.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr][{lane, 3'b000} +: BYTE_W] <= wbyte;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Instruction memory owner for polirv: loads a byte-stream image, holds the core in
// reset until the image is complete, then serves single-cycle fetches.
//   clk, rst     : clock, synchronous active-high reset
//   ld           : load channel (slave side)
//   i_mem_addr   : fetch byte address (low two bits ignored)
//   i_mem_data   : fetched word, zero outside RUN
//   core_rst_n   : low holds polirv in reset
//   done         : high in RUN
//   err          : sticky overflow flag, cleared by rst or ld_start
//   words_loaded : words written by the current/last load (partial word counts)
module imem_loader
  import polirv_pkg::*;
#(
  parameter int unsigned i_addr_bits = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  imem_loader_if.slave           ld,
  input  logic [i_addr_bits-1:0] i_mem_addr,
  output logic [INSTR_W-1:0]     i_mem_data,
  output logic                   core_rst_n,
  output logic                   done,
  output logic                   err,
  output logic [i_addr_bits-2:0] words_loaded
);

  localparam int unsigned WADDR_W = i_addr_bits - 2;
  localparam int unsigned PTR_W   = i_addr_bits - 1;
  localparam int unsigned DEPTH   = 1 << WADDR_W;

  ld_state_t          state_q, state_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [PTR_W-1:0]   word_ptr_q, word_ptr_d;
  logic [PTR_W-1:0]   words_d;
  logic               xfer, full, we;
  logic [INSTR_W-1:0] rdata;
  logic               addr_lane_unused;

  // Fetches are word aligned; the lane bits carry no information here.
  assign addr_lane_unused = ^i_mem_addr[1:0];

  // Outputs decoded straight from the state register: no path from ld_* to ld_ready.
  assign ld.ld_ready = (state_q == LOAD);
  assign core_rst_n  = (state_q == RUN);
  assign done        = (state_q == RUN);

  // A byte arriving with ld_start is discarded along with the old image.
  assign xfer = (state_q == LOAD) && ld.ld_valid && !ld.ld_start;
  assign full = (word_ptr_q == PTR_W'(DEPTH)) && (byte_cnt_q == 2'd0);
  assign we   = xfer && !full;

  // Position after the current transfer; words_loaded counts a partial word as one.
  always_comb begin
    byte_cnt_d = byte_cnt_q + 2'd1;
    word_ptr_d = (byte_cnt_q == 2'd3) ? word_ptr_q + PTR_W'(1) : word_ptr_q;
    words_d    = word_ptr_d + PTR_W'(byte_cnt_d != 2'd0);
  end

  // Next-state logic; ld_start overrides everything but rst.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: ;
      LOAD: begin
        if (xfer) begin
          if (full)             state_d = IDLE;
          else if (ld.ld_last)  state_d = RUN;
        end
      end
      RUN:  ;
      default: state_d = IDLE;
    endcase
    if (ld.ld_start) state_d = LOAD;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Load position, word count and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst || ld.ld_start) begin
      byte_cnt_q   <= '0;
      word_ptr_q   <= '0;
      words_loaded <= '0;
      err          <= 1'b0;
    end else if (xfer) begin
      if (full) begin
        err <= 1'b1;
      end else begin
        byte_cnt_q   <= byte_cnt_d;
        word_ptr_q   <= word_ptr_d;
        words_loaded <= words_d;
      end
    end
  end

  imem_bank #(
    .WADDR_W (WADDR_W)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .clr   (ld.ld_start),
    .we    (we),
    .waddr (word_ptr_q[WADDR_W-1:0]),
    .lane  (byte_cnt_q),
    .wbyte (ld.ld_byte),
    .raddr (i_mem_addr[i_addr_bits-1:2]),
    .rdata (rdata)
  );

  assign i_mem_data = (state_q == RUN) ? rdata : '0;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction-side upstream stage of polirv: owns the instruction memory and serves the core's fetch port (i_mem_addr → i_mem_data).
- Accepts a program image as a byte stream over a valid/ready handshake.
- Holds the core in reset (core_rst_n low) until a complete image is loaded, then releases it.
- Reloading at any time re-asserts core reset, clears memory and restarts loading.

Parameters:
- i_addr_bits, 6, width of the core's byte address into instruction memory; memory depth = 2^(i_addr_bits-2) 32-bit words (16 at default).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active high.
- ld_start  input  1  pulse: begin a new load (clears memory, holds core in reset).
- ld_valid  input  1  ld_byte is valid this cycle.
- ld_byte  input  8  program byte, little-endian within each word.
- ld_last  input  1  qualifies ld_byte as the final byte of the image.
- ld_ready  output  1  loader accepts a byte this cycle.
- i_mem_addr  input  i_addr_bits  fetch byte address from polirv.
- i_mem_data  output  32  instruction word to polirv.
- core_rst_n  output  1  drives polirv rst_n; low = core held in reset.
- done  output  1  high in RUN.
- err  output  1  sticky overflow flag; cleared by rst or ld_start.
- words_loaded  output  i_addr_bits-1  count of words written in the last/current load (partial word counts as one).

Behaviour:
- Clock and reset are decided: one clock clk; reset rst is synchronous and active-high.
- Reset:
  - State = IDLE.
  - All memory words = 0; byte_cnt = 0; word_ptr = 0; words_loaded = 0; err = 0.
  - ld_ready = 0, core_rst_n = 0, done = 0, i_mem_data = 0.
- States: IDLE, LOAD, RUN. All outputs are registered or decoded from state; no combinational path from ld_* to ld_ready.
- IDLE:
  - core_rst_n = 0, ld_ready = 0.
  - ld_start → LOAD.
  - Entered after reset, or after an overflow error.
- ld_start, accepted in any state (highest priority after rst):
  - Next cycle the state is LOAD.
  - All memory words cleared to 0; byte_cnt, word_ptr, words_loaded and err cleared.
  - A byte presented in the same cycle as ld_start is ignored.
- LOAD:
  - ld_ready = 1, core_rst_n = 0.
  - Transfer occurs when ld_valid && ld_ready. The byte is written to lane byte_cnt (bits 8*byte_cnt+7:8*byte_cnt) of mem[word_ptr].
  - byte_cnt increments mod 4. On wrap (byte 3 written), word_ptr increments.
  - words_loaded = word_ptr + (byte_cnt != 0), updated each transfer.
  - Transfer with ld_last = 1 → RUN next cycle. Unwritten lanes of a partial word stay 0.
  - Overflow: a transfer when word_ptr == depth and byte_cnt == 0 (memory full) is not written. It sets err = 1 and goes to IDLE. This applies even if ld_last is set.
  - An image of exactly depth*4 bytes ending with ld_last succeeds.
- RUN:
  - core_rst_n = 1 from the first cycle in RUN (registered; one cycle after the ld_last transfer). done = 1, ld_ready = 0.
  - ld_valid is ignored.
- Fetch port:
  - i_mem_data = mem[i_mem_addr[i_addr_bits-1:2]], combinational, in RUN only. This matches polirv's single-cycle fetch.
  - i_mem_addr[1:0] is ignored (word-aligned).
  - Outside RUN, i_mem_data = 0.
- Simultaneous events, in priority order: rst > ld_start > overflow > ld_last > normal transfer.
- Reset mid-load discards the partial image and returns to IDLE with memory cleared.

Decomposition:
- Shared package polirv_pkg holds:
  - state enum ld_state_t {IDLE, LOAD, RUN};
  - constant INSTR_W = 32;
  - constant BYTE_W = 8.
- Sub-module imem_bank: a 2^(i_addr_bits-2) × 32 array with:
  - synchronous byte-lane write (we, waddr, lane, wbyte);
  - synchronous clear-all;
  - asynchronous read port.
- imem_loader instantiates imem_bank and holds the FSM and counters.

Test Plan:
- Reset, then rst=0 for 5 cycles with no stimulus → core_rst_n=0, ld_ready=0, done=0, i_mem_data=0 at every address.
- ld_start, then 8 bytes 13 00 00 00 93 00 10 00 (last flagged) → words_loaded=2. One cycle later core_rst_n=1, done=1. i_mem_addr=0 → 0x00000013. i_mem_addr=4 → 0x00100093. i_mem_addr=5 → 0x00100093.
- Partial image: 5 bytes AA BB CC DD EE with last flagged → mem[1]=0x000000EE, words_loaded=2. i_mem_addr=8 → 0x00000000.
- ld_valid toggled every other cycle during the load → only handshaked bytes are stored, and the image matches the contiguous-byte case.
- Overflow at default depth:
  - 64 bytes without last, then a 65th byte → err=1, state IDLE, core_rst_n=0, mem[0..15] hold the first 64 bytes.
  - Separately, exactly 64 bytes with last on byte 64 → RUN with err=0.
- Reload and reset:
  - In RUN, pulse ld_start → core_rst_n=0 next cycle, all words read 0 once RUN is reached again.
  - Assert rst mid-LOAD after 3 bytes → IDLE, byte_cnt=0, err=0.
